// File: rtl/puf_pkg.sv
// Shared FSM state type, bus widths and the majority-vote helper for the
// PUF evaluation controller.
package puf_pkg;

    localparam int SEL_W  = 4;
    localparam int CNT_W  = 16;
    localparam int CHAL_W = 2 * SEL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_STOP,
        ST_COMPARE,
        ST_FINISH
    } puf_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Request, oscillator-control and counter signals between a PUF evaluation
// requester (master) and the evaluation controller (slave).
interface puf_eval_ctrl_if #(
    parameter int NBITS = 8
);
    import puf_pkg::*;

    logic              start;
    logic              abort;
    logic [CHAL_W-1:0] challenge;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;

    logic              ro_en;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              cnt_clr;
    logic              busy;
    logic              done;
    logic [NBITS-1:0]  response;
    logic              tie;

    modport master (
        output start, abort, challenge, cnt_a, cnt_b,
        input  ro_en, sel_a, sel_b, cnt_clr, busy, done, response, tie
    );

    modport slave (
        input  start, abort, challenge, cnt_a, cnt_b,
        output ro_en, sel_a, sel_b, cnt_clr, busy, done, response, tie
    );

endinterface

// File: rtl/puf_win_timer.sv
// Loadable down-counter that times both the oscillator window and the settle
// wait. zero_o is high while the count sits at zero; it never wraps.
module puf_win_timer
    import puf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/puf_eval_ctrl.sv
// Ring-oscillator PUF evaluation controller: one CLEAR/MEASURE/STOP/COMPARE pass
// per response bit. Define PUF_MAJORITY_EN for three passes per bit with a vote.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int NBITS         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    puf_eval_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] WIN_LOAD    = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NBITS - 1);

    puf_state_e        state_q;
    puf_state_e        state_d;
    logic [CHAL_W-1:0] chal_q;
    logic [SEL_W-1:0]  idx_q;
    logic [NBITS-1:0]  resp_q;
    logic              tie_q;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              cmp_gt;
    logic              cmp_eq;
    logic              bit_val;
    logic              last_pass;

    assign cmp_gt = (bus.cnt_a > bus.cnt_b);
    assign cmp_eq = (bus.cnt_a == bus.cnt_b);

`ifdef PUF_MAJORITY_EN
    logic [1:0] pass_q;
    logic [1:0] vote_q;

    assign last_pass = (pass_q == 2'd2);
    assign bit_val   = majority3(vote_q[0], vote_q[1], cmp_gt);

    // The first two comparisons of a bit are banked; the third resolves the vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            vote_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (bus.start) begin
                pass_q <= '0;
                vote_q <= '0;
            end
        end else if (!bus.abort && state_q == ST_COMPARE) begin
            if (last_pass) begin
                pass_q <= '0;
                vote_q <= '0;
            end else begin
                pass_q            <= pass_q + 2'd1;
                vote_q[pass_q[0]] <= cmp_gt;
            end
        end
    end
`else
    assign last_pass = 1'b1;
    assign bit_val   = cmp_gt;
`endif

    puf_win_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .zero_o    (tmr_zero)
    );

    // Arm the window on leaving CLEAR, and the settle wait on leaving MEASURE.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = WIN_LOAD;
        if (state_q == ST_CLEAR) begin
            tmr_load = 1'b1;
        end else if (state_q == ST_MEASURE && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_MEASURE;
            ST_MEASURE: if (tmr_zero) state_d = ST_STOP;
            ST_STOP:    if (tmr_zero) state_d = ST_COMPARE;
            ST_COMPARE: state_d = (last_pass && idx_q == LAST_IDX) ? ST_FINISH : ST_CLEAR;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    // Abort leaves response and tie holding whatever was collected so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q <= '0;
            idx_q  <= '0;
            resp_q <= '0;
            tie_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (bus.start) begin
                chal_q <= bus.challenge;
                idx_q  <= '0;
                resp_q <= '0;
                tie_q  <= 1'b0;
            end
        end else if (!bus.abort && state_q == ST_COMPARE) begin
            if (cmp_eq) begin
                tie_q <= 1'b1;
            end
            if (last_pass) begin
                for (int i = 0; i < NBITS; i++) begin
                    if (idx_q == SEL_W'(i)) begin
                        resp_q[i] <= bit_val;
                    end
                end
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.ro_en    = (state_q == ST_MEASURE);
        bus.cnt_clr  = (state_q == ST_CLEAR);
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = (state_q == ST_FINISH);
        bus.sel_a    = chal_q[SEL_W-1:0] ^ idx_q;
        bus.sel_b    = chal_q[CHAL_W-1:SEL_W] ^ idx_q;
        bus.response = resp_q;
        bus.tie      = tie_q;
    end

endmodule
